cbd_write_buffer: RTL and testbench

Write buffer downstream of the CBD sampler: it accepts one 48-bit word of four 12-bit signed centred-binomial coefficients per valid cycle, together with the word's coefficient address. It reduces each coefficient into [0, Q-1] and queues the words in a small FIFO. It then drains them as pairs of coefficients into a 24-bit-wide, 128-entry polynomial RAM. It signals completion after the 256th coefficient has been written and raises `full` so upstream control can stop requesting bits.

---
 rtl/cbd_write_buffer.sv | 257 +++++++++++++++++++++++++
 tb/tb_cbd_write_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cbd_write_buffer.sv
// cbd_write_buffer
// Accepts 48-bit words of four signed CBD coefficients, reduces each into
// [0, Q-1], queues them in a small FIFO and drains each word as two
// 24-bit coefficient pairs into a 128 x 24 polynomial RAM.
module cbd_write_buffer #(
  parameter int Q      = 3329,
  parameter int DEPTH  = 4,
  parameter int COEFFS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [47:0] in_data,
  input  logic [7:0]  in_addr,
  output logic        full,
  output logic        busy,
  output logic        mem_we,
  output logic [6:0]  mem_addr,
  output logic [23:0] mem_wdata,
  output logic        poly_done,
  output logic        err
);

  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [11:0]     Q12      = 12'(Q);
  localparam logic [AW:0]     DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   PTR_INC  = AW'(1);
  localparam logic [AW:0]     OCC_INC  = (AW+1)'(1);
  localparam logic [8:0]      COEFFS_C = 9'(COEFFS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  // Negative coefficients are lifted by Q; the 12-bit wrap removes the sign.
  function automatic logic [11:0] reduce_coeff(input logic [11:0] c);
    logic [11:0] r;
    if (c[11]) begin
      r = c + Q12;
    end else begin
      r = c;
    end
    return r;
  endfunction

  // Legal sampler output is -3..3.
  function automatic logic coeff_in_range(input logic [11:0] c);
    logic ok;
    if (c[11]) begin
      ok = (c >= 12'hFFD);
    end else begin
      ok = (c <= 12'd3);
    end
    return ok;
  endfunction

  // FIFO storage: reduced coefficients plus word address bits [7:2]
  logic [47:0]   fifo_data_r [DEPTH];
  logic [5:0]    fifo_addr_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   occ_r;
  logic [AW:0]   occ_next_s;

  state_t        state_r;
  state_t        state_next_s;
  logic [8:0]    count_r;
  logic [8:0]    count_next_s;
  logic [8:0]    count_plus_s;

  logic          full_r;
  logic          busy_r;
  logic          mem_we_r;
  logic [6:0]    mem_addr_r;
  logic [23:0]   mem_wdata_r;
  logic          poly_done_r;
  logic          err_r;

  logic          we_next_s;
  logic [6:0]    addr_next_s;
  logic [23:0]   wdata_next_s;
  logic          done_next_s;
  logic          err_next_s;

  logic [47:0]   red_data_s;
  logic          range_err_s;
  logic          accept_s;
  logic          pop_s;
  logic [47:0]   head_data_s;
  logic [5:0]    head_addr_s;

  assign head_data_s  = fifo_data_r[rd_ptr_r];
  assign head_addr_s  = fifo_addr_r[rd_ptr_r];
  assign count_plus_s = count_r + 9'd4;

  // A start pulse overrides any enqueue or pop in the same cycle.
  assign accept_s = in_valid && (state_r != IDLE) && !full_r && !start;
  assign pop_s    = (state_r == HI) && !start;

  // Reduce the four incoming coefficients and flag any out-of-range value
  always_comb begin
    red_data_s  = 48'd0;
    range_err_s = 1'b0;
    for (int k = 0; k < 4; k++) begin
      red_data_s[12*k +: 12] = reduce_coeff(in_data[12*k +: 12]);
      if (!coeff_in_range(in_data[12*k +: 12])) begin
        range_err_s = 1'b1;
      end else begin
        range_err_s = range_err_s;
      end
    end
  end

  // Next FIFO occupancy
  always_comb begin
    occ_next_s = occ_r;
    if (start) begin
      occ_next_s = {(AW+1){1'b0}};
    end else begin
      case ({accept_s, pop_s})
        2'b10:   occ_next_s = occ_r + OCC_INC;
        2'b01:   occ_next_s = occ_r - OCC_INC;
        default: occ_next_s = occ_r;
      endcase
    end
  end

  // Sticky error: drops, input in IDLE, bad coefficients, misaligned address
  always_comb begin
    err_next_s = err_r;
    if (start) begin
      err_next_s = 1'b0;
    end else if (in_valid && ((state_r == IDLE) || full_r)) begin
      err_next_s = 1'b1;
    end else if (accept_s && (range_err_s || (in_addr[1:0] != 2'b00))) begin
      err_next_s = 1'b1;
    end else begin
      err_next_s = err_r;
    end
  end

  // Drain FSM: next state and next registered RAM-port values
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    we_next_s    = 1'b0;
    addr_next_s  = mem_addr_r;
    wdata_next_s = mem_wdata_r;
    done_next_s  = 1'b0;
    if (start) begin
      state_next_s = LO;
      count_next_s = 9'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_next_s = IDLE;
        end
        LO: begin
          if (occ_r != {(AW+1){1'b0}}) begin
            we_next_s    = 1'b1;
            addr_next_s  = {head_addr_s, 1'b0};
            wdata_next_s = head_data_s[23:0];
            state_next_s = HI;
          end else begin
            state_next_s = LO;
          end
        end
        HI: begin
          we_next_s    = 1'b1;
          addr_next_s  = {head_addr_s, 1'b1};
          wdata_next_s = head_data_s[47:24];
          count_next_s = count_plus_s;
          if (count_plus_s == COEFFS_C) begin
            done_next_s  = 1'b1;
            state_next_s = IDLE;
          end else begin
            state_next_s = LO;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // Write accepted words into FIFO storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_r[i] <= 48'd0;
        fifo_addr_r[i] <= 6'd0;
      end
    end else if (accept_s) begin
      fifo_data_r[wr_ptr_r] <= red_data_s;
      fifo_addr_r[wr_ptr_r] <= in_addr[7:2];
    end
  end

  // FIFO pointers and occupancy; start flushes everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      occ_r    <= {(AW+1){1'b0}};
    end else if (start) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      occ_r    <= {(AW+1){1'b0}};
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_INC;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_INC;
      end
      occ_r <= occ_next_s;
    end
  end

  // State, coefficient count and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      count_r     <= 9'd0;
      full_r      <= 1'b0;
      busy_r      <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 7'd0;
      mem_wdata_r <= 24'd0;
      poly_done_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      count_r     <= count_next_s;
      full_r      <= (occ_next_s == DEPTH_C);
      busy_r      <= (state_r != IDLE);
      mem_we_r    <= we_next_s;
      mem_addr_r  <= addr_next_s;
      mem_wdata_r <= wdata_next_s;
      poly_done_r <= done_next_s;
      err_r       <= err_next_s;
    end
  end

  assign full      = full_r;
  assign busy      = busy_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign poly_done = poly_done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_cbd_write_buffer.sv
// Directed self-checking bench for cbd_write_buffer.
module tb_cbd_write_buffer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [47:0] in_data;
  logic [7:0]  in_addr;
  logic        full;
  logic        busy;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [23:0] mem_wdata;
  logic        poly_done;
  logic        err;

  int errors = 0;
  int checks = 0;

  // coefficients c0=-1, c1=0, c2=-3, c3=3
  localparam logic [47:0] W1 = 48'h003_FFD_000_FFF;

  cbd_write_buffer #(.Q(3329), .DEPTH(4), .COEFFS(256)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_addr(in_addr), .full(full), .busy(busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .poly_done(poly_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one word in the current cycle, then idle two cycles (no checks).
  task automatic send_word(input logic [47:0] d, input logic [7:0] a);
    in_valid = 1'b1; in_data = d; in_addr = a;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 48'd0; in_addr = 8'd0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL rst_we got %b exp 0", mem_we); end
    checks++; if (mem_addr !== 7'd0)   begin errors++; $display("FAIL rst_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 24'd0) begin errors++; $display("FAIL rst_wdata got %h exp 0", mem_wdata); end
    checks++; if (full !== 1'b0)       begin errors++; $display("FAIL rst_full got %b exp 0", full); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (poly_done !== 1'b0)  begin errors++; $display("FAIL rst_done got %b exp 0", poly_done); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL rst_err got %b exp 0", err); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_reset busy got %b exp 0", busy); end
  endtask

  task automatic test_poly;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    in_valid = 1'b1; in_data = W1; in_addr = 8'd0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk); in_valid = 1'b0;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL poly_idle_we k=%0d got %b exp 0", k, mem_we); end
      @(negedge clk);
      checks++; if (mem_we !== 1'b1 || mem_addr !== 7'(2*k) || mem_wdata !== 24'h000D00)
        begin errors++; $display("FAIL poly_lo k=%0d got we=%b a=%0d d=%h exp we=1 a=%0d d=000d00", k, mem_we, mem_addr, mem_wdata, 2*k); end
      @(negedge clk);
      checks++; if (mem_we !== 1'b1 || mem_addr !== 7'(2*k+1) || mem_wdata !== 24'h003CFE)
        begin errors++; $display("FAIL poly_hi k=%0d got we=%b a=%0d d=%h exp we=1 a=%0d d=003cfe", k, mem_we, mem_addr, mem_wdata, 2*k+1); end
      checks++; if (poly_done !== (k == 63)) begin errors++; $display("FAIL poly_done k=%0d got %b exp %b", k, poly_done, (k == 63)); end
      if (k == 63) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL poly_busy_at_done got %b exp 1", busy); end
      end
      if (k < 63) begin
        in_valid = 1'b1; in_data = W1; in_addr = 8'(4*(k+1));
      end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL poly_busy_after got %b exp 0", busy); end
    checks++; if (poly_done !== 1'b0) begin errors++; $display("FAIL poly_done_after got %b exp 0", poly_done); end
    checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL poly_we_after got %b exp 0", mem_we); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL poly_err got %b exp 0", err); end
  endtask

  task automatic test_back_to_back;
    int exp_addr [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 14, 15, 18, 19};
    logic exp_full;
    @(negedge clk); start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk); start = 1'b0;
      exp_full = (n == 7) || (n == 9) || (n == 11);
      checks++; if (full !== exp_full) begin errors++; $display("FAIL b2b_full n=%0d got %b exp %b", n, full, exp_full); end
      if (n >= 3 && n <= 18) begin
        checks++; if (mem_we !== 1'b1 || mem_addr !== 7'(exp_addr[n-3]) ||
                      mem_wdata !== (((n - 3) % 2 == 0) ? 24'h001000 : 24'h003002))
          begin errors++; $display("FAIL b2b_write n=%0d got we=%b a=%0d d=%h exp a=%0d", n, mem_we, mem_addr, mem_wdata, exp_addr[n-3]); end
      end else begin
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL b2b_nowrite n=%0d got %b exp 0", n, mem_we); end
      end
      if (n == 7) begin
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err_early got %b exp 0", err); end
      end
      if (n == 8) begin
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL b2b_err_drop got %b exp 1", err); end
      end
      if (n <= 10) begin
        in_valid = 1'b1; in_data = 48'h003_002_001_000; in_addr = 8'(4*(n-1));
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_range;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    in_valid = 1'b1; in_data = 48'h000_000_000_005; in_addr = 8'h10;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 7'd8 || mem_wdata !== 24'h000005)
      begin errors++; $display("FAIL range_lo got we=%b a=%0d d=%h exp we=1 a=8 d=000005", mem_we, mem_addr, mem_wdata); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL range_err got %b exp 1", err); end
    @(negedge clk);
    checks++; if (mem_addr !== 7'd9 || mem_wdata !== 24'h000000)
      begin errors++; $display("FAIL range_hi got a=%0d d=%h exp a=9 d=000000", mem_addr, mem_wdata); end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL start_clears_err got %b exp 0", err); end
    in_valid = 1'b1; in_data = 48'h001_001_001_001; in_addr = 8'h06;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 7'd2 || mem_wdata !== 24'h001001)
      begin errors++; $display("FAIL misalign_lo got we=%b a=%0d d=%h exp we=1 a=2 d=001001", mem_we, mem_addr, mem_wdata); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL misalign_err got %b exp 1", err); end
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 7'd3)
      begin errors++; $display("FAIL misalign_hi got we=%b a=%0d exp we=1 a=3", mem_we, mem_addr); end
  endtask

  task automatic test_async_reset;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    in_valid = 1'b1; in_data = 48'h000_000_000_005; in_addr = 8'h00;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || busy !== 1'b1 || err !== 1'b1)
      begin errors++; $display("FAIL pre_reset got we=%b busy=%b err=%b exp 1 1 1", mem_we, busy, err); end
    reset = 1'b0;
    #1;
    checks++; if ({full, busy, mem_we, mem_addr, mem_wdata, poly_done, err} !== 37'd0)
      begin errors++; $display("FAIL async_reset got full=%b busy=%b we=%b a=%h d=%h done=%b err=%b exp all 0",
                              full, busy, mem_we, mem_addr, mem_wdata, poly_done, err); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data = W1; in_addr = 8'h00;
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL idle_nowrite i=%0d got %b exp 0", i, mem_we); end
    end
    checks++; if (err !== 1'b1)  begin errors++; $display("FAIL idle_valid_err got %b exp 1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_restart;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      send_word((k == 5) ? 48'h000_000_000_005 : W1, 8'(4*k));
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL restart_pre_err got %b exp 1", err); end
    in_valid = 1'b1; in_data = W1; in_addr = 8'd80;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL restart_suppress got %b exp 0", mem_we); end
    checks++; if (err !== 1'b0)    begin errors++; $display("FAIL restart_err got %b exp 0", err); end
    in_valid = 1'b1; in_data = W1; in_addr = 8'd0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (poly_done !== (k == 63) || mem_addr !== 7'(2*k+1))
        begin errors++; $display("FAIL restart_done k=%0d got done=%b a=%0d exp done=%b a=%0d", k, poly_done, mem_addr, (k == 63), 2*k+1); end
      if (k < 63) begin
        in_valid = 1'b1; in_data = W1; in_addr = 8'(4*(k+1));
      end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_busy got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_poly();
    test_back_to_back();
    test_range();
    test_async_reset();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
